// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - two-requester front end that shares one fixed-latency multiplier
// Optional macro MUL_ARB_FIXED_PRIO_EN: requester 0 always wins a tie instead of round-robin.
module mul_share_arbiter #(
    parameter int MUL_LATENCY = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    output logic        resp0_valid,
    output logic [63:0] resp0_r,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        resp1_valid,
    output logic [63:0] resp1_r,
    output logic        mul_valid_in,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_r,
    output logic        busy,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [5:0] LAT = 6'(MUL_LATENCY);

    state_t      r_state;
    logic        r_last_grant;
    logic        r_grant_id;
    logic [5:0]  r_wait_cnt;
    logic        r_mul_valid_in;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic        r_resp0_valid;
    logic        r_resp1_valid;
    logic [63:0] r_resp0_r;
    logic [63:0] r_resp1_r;
    logic [15:0] r_op_count;

    logic w_idle;
    logic w_pick0;
    logic w_pick1;

    assign w_idle = (r_state == S_IDLE);

`ifdef MUL_ARB_FIXED_PRIO_EN
    assign w_pick1 = req1_valid && !req0_valid;
`else
    // On a tie requester 1 wins only when requester 0 held the previous grant.
    assign w_pick1 = req1_valid && (!req0_valid || !r_last_grant);
`endif
    assign w_pick0 = req0_valid && !w_pick1;

    assign req0_ready   = w_idle && w_pick0;
    assign req1_ready   = w_idle && w_pick1;
    assign busy         = !w_idle;
    assign mul_valid_in = r_mul_valid_in;
    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign resp0_valid  = r_resp0_valid;
    assign resp1_valid  = r_resp1_valid;
    assign resp0_r      = r_resp0_r;
    assign resp1_r      = r_resp1_r;
    assign op_count     = r_op_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_last_grant   <= 1'b1;
            r_grant_id     <= 1'b0;
            r_wait_cnt     <= 6'd0;
            r_mul_valid_in <= 1'b0;
            r_mul_a        <= 32'd0;
            r_mul_b        <= 32'd0;
            r_resp0_valid  <= 1'b0;
            r_resp1_valid  <= 1'b0;
            r_resp0_r      <= 64'd0;
            r_resp1_r      <= 64'd0;
            r_op_count     <= 16'd0;
        end else begin
            r_mul_valid_in <= 1'b0;
            r_resp0_valid  <= 1'b0;
            r_resp1_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick0 || w_pick1) begin
                        r_grant_id     <= w_pick1;
                        r_last_grant   <= w_pick1;
                        r_mul_a        <= w_pick1 ? req1_a : req0_a;
                        r_mul_b        <= w_pick1 ? req1_b : req0_b;
                        r_mul_valid_in <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= LAT;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 6'd1;
                    // mul_r is valid only in this cycle; it lands straight in the response register.
                    if (r_wait_cnt == 6'd1) begin
                        if (r_grant_id) begin
                            r_resp1_r     <= mul_r;
                            r_resp1_valid <= 1'b1;
                        end else begin
                            r_resp0_r     <= mul_r;
                            r_resp0_valid <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_op_count <= r_op_count + 16'd1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed bench for mul_share_arbiter at MUL_LATENCY 33 and 1
module tb_mul_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [63:0] resp0_r, resp1_r, mul_r;
    logic        mul_valid_in, busy;
    logic [31:0] mul_a, mul_b;
    logic [15:0] op_count;

    logic        d2_req0_valid, d2_req1_valid;
    logic [31:0] d2_req0_a, d2_req0_b, d2_req1_a, d2_req1_b;
    logic        d2_req0_ready, d2_req1_ready, d2_resp0_valid, d2_resp1_valid;
    logic [63:0] d2_resp0_r, d2_resp1_r, d2_mul_r;
    logic        d2_mul_valid_in, d2_busy;
    logic [31:0] d2_mul_a, d2_mul_b;
    logic [15:0] d2_op_count;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mul_share_arbiter #(.MUL_LATENCY(33)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .resp0_valid(resp0_valid), .resp0_r(resp0_r),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp1_valid(resp1_valid), .resp1_r(resp1_r),
        .mul_valid_in(mul_valid_in), .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r),
        .busy(busy), .op_count(op_count)
    );

    mul_share_arbiter #(.MUL_LATENCY(1)) dut2 (
        .clk(clk), .reset(reset),
        .req0_valid(d2_req0_valid), .req0_a(d2_req0_a), .req0_b(d2_req0_b), .req0_ready(d2_req0_ready),
        .resp0_valid(d2_resp0_valid), .resp0_r(d2_resp0_r),
        .req1_valid(d2_req1_valid), .req1_a(d2_req1_a), .req1_b(d2_req1_b), .req1_ready(d2_req1_ready),
        .resp1_valid(d2_resp1_valid), .resp1_r(d2_resp1_r),
        .mul_valid_in(d2_mul_valid_in), .mul_a(d2_mul_a), .mul_b(d2_mul_b), .mul_r(d2_mul_r),
        .busy(d2_busy), .op_count(d2_op_count)
    );

    // Multiplier models: product is presented only in the cycle it becomes valid, garbage otherwise.
    logic [63:0] m_prod, m2_prod;
    logic [6:0]  m_cnt = 7'd0;
    logic [6:0]  m2_cnt = 7'd0;
    always @(posedge clk) begin
        if (mul_valid_in) begin
            m_prod <= {32'd0, mul_a} * {32'd0, mul_b};
            m_cnt  <= 7'd33;
        end else if (m_cnt != 7'd0) m_cnt <= m_cnt - 7'd1;
        if (d2_mul_valid_in) begin
            m2_prod <= {32'd0, d2_mul_a} * {32'd0, d2_mul_b};
            m2_cnt  <= 7'd1;
        end else if (m2_cnt != 7'd0) m2_cnt <= m2_cnt - 7'd1;
    end
    assign mul_r    = (m_cnt == 7'd1)  ? m_prod  : 64'hDEAD_BEEF_0BAD_F00D;
    assign d2_mul_r = (m2_cnt == 7'd1) ? m2_prod : 64'hDEAD_BEEF_0BAD_F00D;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        d2_req0_valid = 0; d2_req1_valid = 0; d2_req0_a = 0; d2_req0_b = 0; d2_req1_a = 0; d2_req1_b = 0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
        tests_run++; if ({resp0_valid, resp1_valid, mul_valid_in, busy} !== 4'b0000) begin fails++; $display("FAIL reset_flags got=%b exp=0000", {resp0_valid, resp1_valid, mul_valid_in, busy}); end
        tests_run++; if ({resp0_r, resp1_r} !== 128'd0) begin fails++; $display("FAIL reset_resp_r got=%h_%h exp=0", resp0_r, resp1_r); end
        tests_run++; if ({mul_a, mul_b} !== 64'd0) begin fails++; $display("FAIL reset_mul_ops got=%h exp=0", {mul_a, mul_b}); end
        tests_run++; if (op_count !== 16'd0) begin fails++; $display("FAIL reset_op_count got=%h exp=0", op_count); end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        req0_a = 3; req0_b = 5; req0_valid = 1; #1;
        tests_run++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
        step(); req0_valid = 0;
        tests_run++; if ({mul_valid_in, busy, mul_a, mul_b} !== {2'b11, 32'd3, 32'd5}) begin fails++; $display("FAIL single_issue got=%b%b a=%0d b=%0d exp=11 a=3 b=5", mul_valid_in, busy, mul_a, mul_b); end
        step();
        tests_run++; if ({mul_valid_in, mul_a, mul_b} !== {1'b0, 32'd3, 32'd5}) begin fails++; $display("FAIL single_wait got=%b a=%0d b=%0d exp=0 a=3 b=5", mul_valid_in, mul_a, mul_b); end
        n = 2;
        while (!resp0_valid && n < 80) begin step(); n++; end
        tests_run++; if (n !== 35) begin fails++; $display("FAIL single_latency got=T+%0d exp=T+35", n); end
        tests_run++; if (resp0_r !== 64'd15) begin fails++; $display("FAIL single_product got=%0d exp=15", resp0_r); end
        tests_run++; if (resp1_valid !== 1'b0) begin fails++; $display("FAIL single_resp1 got=%b exp=0", resp1_valid); end
        step();
        tests_run++; if ({resp0_valid, busy, op_count} !== {2'b00, 16'd1}) begin fails++; $display("FAIL single_after got=%b%b cnt=%0d exp=00 cnt=1", resp0_valid, busy, op_count); end
        tests_run++; if (resp0_r !== 64'd15) begin fails++; $display("FAIL single_hold got=%0d exp=15", resp0_r); end
    endtask

    task automatic test_tie();
        int first, both;
        logic got0, got1, hs0, hs1;
        logic [63:0] r0, r1;
        do_reset();
        first = -1; both = 0; got0 = 0; got1 = 0; r0 = 0; r1 = 0;
        req0_a = 7; req0_b = 9; req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF;
        req0_valid = 1; req1_valid = 1;
        for (int c = 0; c < 200 && !(got0 && got1); c++) begin
            #1;
            if (req0_ready && req1_ready) both++;
            hs0 = req0_ready && req0_valid;
            hs1 = req1_ready && req1_valid;
            step();
            if (hs0) req0_valid = 0;
            if (hs1) req1_valid = 0;
            if (resp0_valid) begin got0 = 1; r0 = resp0_r; if (first < 0) first = 0; end
            if (resp1_valid) begin got1 = 1; r1 = resp1_r; if (first < 0) first = 1; end
        end
        tests_run++; if (both !== 0) begin fails++; $display("FAIL tie_both_ready got=%0d cycles exp=0", both); end
        tests_run++; if ({got0, got1} !== 2'b11 || first !== 0) begin fails++; $display("FAIL tie_order got=%b first=%0d exp=11 first=0", {got0, got1}, first); end
        tests_run++; if (r0 !== 64'd63) begin fails++; $display("FAIL tie_resp0 got=%h exp=3f", r0); end
        tests_run++; if (r1 !== 64'hFFFF_FFFE_0000_0001) begin fails++; $display("FAIL tie_resp1 got=%h exp=fffffffe00000001", r1); end
        step();
        tests_run++; if (op_count !== 16'd2) begin fails++; $display("FAIL tie_op_count got=%0d exp=2", op_count); end
    endtask

    task automatic test_priority();
        int seq[3];
        int exp_seq[3];
        int k, c, both;
`ifdef MUL_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0};
`else
        exp_seq = '{0, 1, 0};
`endif
        do_reset();
        seq = '{-1, -1, -1};
        k = 0; c = 0; both = 0;
        req0_a = 1; req0_b = 2; req1_a = 4; req1_b = 4;
        req0_valid = 1; req1_valid = 1;
        while (k < 3 && c < 400) begin
            #1;
            if (req0_ready && req1_ready) both++;
            if (req0_ready) begin seq[k] = 0; k++; end
            else if (req1_ready) begin seq[k] = 1; k++; end
            step(); c++;
            req0_a = req0_a + 1;
        end
        req0_valid = 0; req1_valid = 0;
        tests_run++; if (k !== 3 || both !== 0) begin fails++; $display("FAIL prio_grants got=%0d both=%0d exp=3 both=0", k, both); end
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (seq[i] !== exp_seq[i]) begin fails++; $display("FAIL prio_seq%0d got=%0d exp=%0d", i, seq[i], exp_seq[i]); end
        end
    endtask

    task automatic test_busy_hold();
        int off, busy_err, n;
        do_reset();
        busy_err = 0;
        req0_a = 3; req0_b = 4; req0_valid = 1; #1;
        step(); req0_valid = 0;
        off = 1;
        while (off < 100) begin
            if (off == 5) begin req1_a = 5; req1_b = 6; req1_valid = 1; end
            #1;
            if (busy !== (off <= 35)) busy_err++;
            if (req1_ready) break;
            step(); off++;
        end
        tests_run++; if (off !== 36) begin fails++; $display("FAIL hold_ready_cycle got=T+%0d exp=T+36", off); end
        tests_run++; if (busy_err !== 0) begin fails++; $display("FAIL hold_busy got=%0d bad cycles exp=0", busy_err); end
        step(); req1_valid = 0;
        n = 0;
        while (!resp1_valid && n < 80) begin step(); n++; end
        tests_run++; if (resp1_r !== 64'd30) begin fails++; $display("FAIL hold_resp1 got=%0d exp=30", resp1_r); end
        tests_run++; if (resp0_r !== 64'd12) begin fails++; $display("FAIL hold_resp0_kept got=%0d exp=12", resp0_r); end
        step();
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        seen = 0;
        req0_a = 11; req0_b = 13; req0_valid = 1; #1;
        step(); req0_valid = 0;
        for (int i = 1; i < 10; i++) step();
        tests_run++; if (busy !== 1'b1 || op_count !== 16'd2) begin fails++; $display("FAIL midrst_pre got=%b cnt=%0d exp=1 cnt=2", busy, op_count); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++; if ({busy, mul_valid_in, resp0_valid, resp1_valid} !== 4'b0000) begin fails++; $display("FAIL midrst_flags got=%b exp=0000", {busy, mul_valid_in, resp0_valid, resp1_valid}); end
        tests_run++; if ({mul_a, mul_b, op_count} !== 80'd0) begin fails++; $display("FAIL midrst_regs got a=%h b=%h cnt=%h exp=0", mul_a, mul_b, op_count); end
        tests_run++; if ({resp0_r, resp1_r} !== 128'd0) begin fails++; $display("FAIL midrst_resp_r got=%h_%h exp=0", resp0_r, resp1_r); end
        for (int i = 0; i < 60; i++) begin
            if (resp0_valid || resp1_valid || mul_valid_in) seen++;
            step();
        end
        tests_run++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_resp got=%0d events exp=0", seen); end
    endtask

    task automatic test_wrap_lat1();
        int n;
        force dut2.r_op_count = 16'hFFFF;
        step();
        release dut2.r_op_count;
        step();
        tests_run++; if (d2_op_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload got=%h exp=ffff", d2_op_count); end
        d2_req0_a = 32'h0001_0000; d2_req0_b = 32'h0001_0000; d2_req0_valid = 1; #1;
        tests_run++; if (d2_req0_ready !== 1'b1) begin fails++; $display("FAIL lat1_ready got=%b exp=1", d2_req0_ready); end
        step(); d2_req0_valid = 0;
        n = 1;
        while (!d2_resp0_valid && n < 20) begin step(); n++; end
        tests_run++; if (n !== 3) begin fails++; $display("FAIL lat1_latency got=T+%0d exp=T+3", n); end
        tests_run++; if (d2_resp0_r !== 64'h0000_0001_0000_0000) begin fails++; $display("FAIL lat1_product got=%h exp=100000000", d2_resp0_r); end
        step();
        tests_run++; if (d2_op_count !== 16'h0000) begin fails++; $display("FAIL wrap_op_count got=%h exp=0", d2_op_count); end
        d2_req1_a = 32'hFFFF_FFFF; d2_req1_b = 32'd2; d2_req1_valid = 1; #1;
        step(); d2_req1_valid = 0;
        n = 1;
        while (!d2_resp1_valid && n < 20) begin step(); n++; end
        tests_run++; if (n !== 3 || d2_resp1_r !== 64'h0000_0001_FFFF_FFFE) begin fails++; $display("FAIL lat1_req1 got=T+%0d %h exp=T+3 1fffffffe", n, d2_resp1_r); end
        step();
        tests_run++; if (d2_op_count !== 16'd1) begin fails++; $display("FAIL lat1_op_count got=%0d exp=1", d2_op_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_priority();
        test_busy_hold();
        test_reset_mid_wait();
        test_wrap_lat1();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Shares one iterative multiplier between two requesters (e.g. ALU multiply path and address-generation path).
- Accepts one request at a time using a valid/ready handshake.
- Sequences the multiplier: one-cycle start pulse, fixed-latency wait, result capture.
- Returns the 64-bit product to the requester that issued it.
- Sits between the requesters and a single multiplier instance.

Parameters:
MUL_LATENCY, 33, cycles from the multiplier start pulse (exclusive) to a valid `mul_r` (inclusive); legal range 1..63.

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has operands
req0_a  input  32  requester 0 operand a
req0_b  input  32  requester 0 operand b
req0_ready  output  1  requester 0 request accepted this cycle
resp0_valid  output  1  one-cycle pulse, `resp0_r` valid
resp0_r  output  64  product for requester 0
req1_valid  input  1  requester 1 has operands
req1_a  input  32  requester 1 operand a
req1_b  input  32  requester 1 operand b
req1_ready  output  1  requester 1 request accepted this cycle
resp1_valid  output  1  one-cycle pulse, `resp1_r` valid
resp1_r  output  64  product for requester 1
mul_valid_in  output  1  start pulse to multiplier
mul_a  output  32  operand a to multiplier
mul_b  output  32  operand b to multiplier
mul_r  input  64  multiplier result
busy  output  1  high in any state other than IDLE
op_count  output  16  completed operations, wraps 0xFFFF->0

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Reset values: state=IDLE; all ready, resp_valid and `mul_valid_in` outputs 0; `resp*_r`=0; `mul_a`/`mul_b`=0; `op_count`=0; `last_grant`=1, so requester 0 wins the first tie.
- Reset mid-operation: abort immediately; no response is issued; the multiplier result is discarded.
- Request rule: a requester holds valid and operands stable until its ready is high. A handshake occurs when valid=1 and ready=1 in the same cycle.
- `ready` is combinational from state and valids. It is high only in IDLE, for the granted requester only, and is never high for both requesters.
- IDLE:
  - One valid requester: grant it.
  - Both valid: round-robin, granting the requester not equal to `last_grant`.
  - On grant: latch a, b and grant id; update `last_grant`; go to ISSUE.
- ISSUE (1 cycle): `mul_valid_in`=1; `mul_a`/`mul_b` = latched operands; load `wait_cnt`=MUL_LATENCY; go to WAIT.
- WAIT:
  - `mul_valid_in`=0; `mul_a`/`mul_b` stay at the latched values.
  - Decrement `wait_cnt` each cycle.
  - In the cycle `wait_cnt`==1: capture `mul_r` into the result register, then go to RESP.
- RESP (1 cycle):
  - Assert resp_valid for the grant id only.
  - Drive that `resp*_r` with the captured result. The other requester's `resp_r` holds its previous value.
  - Increment `op_count`; go to IDLE.
- Responses are not back-pressured.
- Latency: handshake in cycle T -> `mul_valid_in` in T+1 -> `mul_r` sampled at the end of T+1+MUL_LATENCY -> resp_valid in T+2+MUL_LATENCY.
- Throughput: one operation per MUL_LATENCY+3 cycles. The next handshake is possible in the cycle after RESP.
- Requests arriving while busy: ready stays 0 and the request is held by the requester; no queuing.
- A requester that deasserts valid before its handshake loses its turn with no side effects.
- Arithmetic: no modification of operands or result; unsigned 32x32->64 is the multiplier's responsibility.

Optional Feature:
MUL_ARB_FIXED_PRIO_EN
- Defined: fixed priority; requester 0 always wins when both are valid. `last_grant` is still updated but ignored.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single op: after reset, req0 a=3 b=5; behavioural multiplier model returns a*b after MUL_LATENCY=33 -> `req0_ready` in T, `mul_valid_in` in T+1, `resp0_valid`=1 with `resp0_r`=15 in T+35, `op_count`=1.
- Tie, round-robin: both valid from reset (req0 7x9, req1 0xFFFFFFFFx0xFFFFFFFF) -> req0 served first (`resp0_r`=63), then req1 (`resp1_r`=0xFFFFFFFE00000001), `op_count`=2; never both ready in one cycle.
- Tie with MUL_ARB_FIXED_PRIO_EN: req0 valid continuously with fresh operands, req1 valid -> req1 never granted while req0 is valid.
- Busy hold: req1 asserts valid during req0's WAIT -> `req1_ready` stays 0 until the cycle after RESP, then handshakes; `busy` deasserts only in IDLE.
- Reset mid-WAIT: reset asserted in cycle T+10 of an op -> next cycle all outputs at reset values; no `resp*_valid` ever appears for the aborted op.
- Counter wrap and MUL_LATENCY=1: preload via 65536 ops (or force) -> `op_count` 0xFFFF->0; with MUL_LATENCY=1, `resp_valid` in T+3 with the correct product.
